// File: rtl/num_pkg.sv
// -----------------------------------------------------------------------------
// num_pkg
// Shared definitions for the number-search block:
//   W        - candidate / number width (5 bits, candidates 0..31)
//   P_MUL*   - bit positions in the property vector and in the search mask
//   NPROP    - number of properties (width of property vector and mask)
//   state_t  - search controller states
// -----------------------------------------------------------------------------
package num_pkg;

  localparam int W       = 5;
  localparam int NPROP   = 5;

  localparam int P_MUL2  = 0;
  localparam int P_MUL3  = 1;
  localparam int P_MUL4  = 2;
  localparam int P_MUL5  = 3;
  localparam int P_MUL30 = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/num_props.sv
// -----------------------------------------------------------------------------
// num_props
// Purely combinational property evaluator for one candidate value.
// Ports:
//   i_n      [W-1:0]     candidate value 0..31
//   o_props  [NPROP-1:0] property flags, indexed by P_MUL2..P_MUL30
// Zero is treated as a multiple of 2 and 4 but not of 3, 5 or 30.
// -----------------------------------------------------------------------------
module num_props
  import num_pkg::*;
(
  input  logic [W-1:0]     i_n,
  output logic [NPROP-1:0] o_props
);

  logic w_nonzero;
  logic w_m2;
  logic w_m3;
  logic w_m4;
  logic w_m5;

  assign w_nonzero = (i_n != '0);
  assign w_m2      = ~i_n[0];
  assign w_m4      = (i_n[1:0] == 2'b00);
  // Constant-divisor modulo on 5 bits folds into a small lookup.
  assign w_m3      = w_nonzero && ((i_n % W'(3)) == '0);
  assign w_m5      = w_nonzero && ((i_n % W'(5)) == '0);

  always_comb begin
    o_props          = '0;
    o_props[P_MUL2]  = w_m2;
    o_props[P_MUL3]  = w_m3;
    o_props[P_MUL4]  = w_m4;
    o_props[P_MUL5]  = w_m5;
    o_props[P_MUL30] = w_m2 & w_m3 & w_m5;
  end

endmodule

// File: rtl/num_search.sv
// -----------------------------------------------------------------------------
// num_search
// Scans candidates 0..31 one per cycle and presents every value whose
// properties satisfy the mask latched at start. Each match is held on
// number/valid until the consumer acks it, then the scan resumes at the
// following candidate.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a new search (accepted in IDLE or DONE)
//   mask   [4:0] required properties (1 = required, 0 = don't care)
//   ack          consumer took the presented number (used in HOLD only)
//   abort        cancel and return to IDLE; beats start and ack
//   number [4:0] last matched value, kept after valid falls
//   valid        number holds an unacknowledged match
//   busy         searching (SCAN or HOLD)
//   done         search finished (DONE)
//   match_count  matches found in the current / last search, 0..32
// -----------------------------------------------------------------------------
module num_search #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] mask,
  input  logic         ack,
  input  logic         abort,
  output logic [W-1:0] number,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic [5:0]   match_count
);

  import num_pkg::*;

  state_t           r_state;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_number;
  logic             r_valid;
  logic [5:0]       r_count;
  logic [NPROP-1:0] r_mask;

  state_t           w_state_next;
  logic [W-1:0]     w_cand_next;
  logic [W-1:0]     w_number_next;
  logic             w_valid_next;
  logic [5:0]       w_count_next;
  logic [NPROP-1:0] w_mask_next;

  logic [NPROP-1:0] w_props;
  logic             w_match;
  logic             w_last;

  num_props u_props (
    .i_n     (r_cand),
    .o_props (w_props)
  );

  // Every required property must hold; unrequired ones are ignored.
  assign w_match = ((w_props & r_mask) == r_mask);
  // The scan stops at the top value instead of wrapping back to zero.
  assign w_last  = (r_cand == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_number <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_mask   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_number <= w_number_next;
      r_valid  <= w_valid_next;
      r_count  <= w_count_next;
      r_mask   <= w_mask_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_number_next = r_number;
    w_valid_next  = r_valid;
    w_count_next  = r_count;
    w_mask_next   = r_mask;

    if (abort) begin
      // Count and last number stay visible so the consumer can inspect them.
      w_state_next = IDLE;
      w_valid_next = 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_mask_next  = mask;
            w_cand_next  = '0;
            w_count_next = '0;
            w_state_next = SCAN;
          end
        end

        SCAN: begin
          if (w_match) begin
            w_number_next = r_cand;
            w_valid_next  = 1'b1;
            w_count_next  = r_count + 6'd1;
            w_state_next  = HOLD;
          end else if (w_last) begin
            w_state_next = DONE;
          end else begin
            w_cand_next = r_cand + W'(1);
          end
        end

        HOLD: begin
          if (ack) begin
            w_valid_next = 1'b0;
            if (w_last) begin
              w_state_next = DONE;
            end else begin
              w_cand_next  = r_cand + W'(1);
              w_state_next = SCAN;
            end
          end
        end

        default: begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end
      endcase
    end
  end

  assign number      = r_number;
  assign valid       = r_valid;
  assign busy        = (r_state == SCAN) || (r_state == HOLD);
  assign done        = (r_state == DONE);
  assign match_count = r_count;

endmodule
